// File: rtl/seven_seg_decoder.sv
// Seven-segment receiver: syncs seg_a..seg_g, debounces, decodes glyph to a 3-bit code.
// Latency: out_valid rises STABLE_CYCLES+2 edges after the input edge at which a new pattern appears.
// Backpressure: one-deep valid/ready slot; a report arriving while the slot is full is discarded with a drop pulse.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode (active-low) segment inputs.
module seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    output logic [2:0] out_code,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       drop
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Blank in the internal active-high domain; an all-off display in either polarity maps here.
    localparam logic [6:0] BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    raw, seg_in, s1, s2;
    logic [6:0]    cand, cand_nxt;
    logic [6:0]    last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    dec_code;
    logic          dec_err;
    logic          take, slot_free;

    assign raw = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

`ifdef SEG_ACTIVE_LOW_EN
    // Common-anode: a lit segment is driven low, so flip to active-high before syncing.
    assign seg_in = ~raw;
`else
    assign seg_in = raw;
`endif

    // Two-flop synchronizer on the whole segment vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= BLANK;
            s2 <= BLANK;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
        end
    end

    // Glyph lookup for the candidate pattern; anything unknown is flagged as an error.
    always_comb begin
        dec_code = 3'd7;
        dec_err  = 1'b1;
        case (cand)
            7'b1111110: begin dec_code = 3'd0; dec_err = 1'b0; end
            7'b0110000: begin dec_code = 3'd1; dec_err = 1'b0; end
            7'b1101101: begin dec_code = 3'd2; dec_err = 1'b0; end
            7'b1111001: begin dec_code = 3'd3; dec_err = 1'b0; end
            7'b1001111: begin dec_code = 3'd4; dec_err = 1'b0; end
            default: ;
        endcase
    end

    // Debounce FSM state, candidate, last-reported pattern and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            cand  <= BLANK;
            last  <= BLANK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: any change restarts the count; an accepted pattern is reported only if new and non-blank.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            HOLD: begin
                if (s2 != cand) begin
                    cand_nxt  = s2;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (s2 != cand) begin
                    cand_nxt = s2;
                    cnt_nxt  = CNT_ONE;
                end else if ((STABLE_CYCLES == 1) || (cnt == CNT_LAST)) begin
                    if ((cand == BLANK) || (cand == last)) begin
                        last_nxt  = cand;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = EMIT;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            EMIT: begin
                last_nxt  = cand;
                state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
        endcase
    end

    assign take      = out_valid && out_ready;
    assign slot_free = !out_valid || take;

    // Output slot: EMIT loads it when free (a same-cycle handshake counts as free), otherwise flags a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code  <= 3'd0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= (state == EMIT) && !slot_free;
            if ((state == EMIT) && slot_free) begin
                out_code  <= dec_code;
                out_err   <= dec_err;
                out_valid <= 1'b1;
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
- Receive-side counterpart of the team's 3-bit to seven-segment encoder. Samples seven raw segment lines (seg_a..seg_g), for example from a display bus or a loopback of the encoder outputs.
- Debounces the pattern, then decodes it back to the 3-bit code.
- Reports each new stable pattern once, through a one-deep valid/ready output slot.
- Used by the multiplier test harness to read back displayed digits.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before it is accepted; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
seg_a  input  1  segment a, asynchronous to clk; same bit applies to seg_b..seg_g
seg_b  input  1  segment b
seg_c  input  1  segment c
seg_d  input  1  segment d
seg_e  input  1  segment e
seg_f  input  1  segment f
seg_g  input  1  segment g
out_code  output  3  decoded value
out_err  output  1  reported pattern is not a legal glyph
out_valid  output  1  report is pending in the output slot
out_ready  input  1  consumer accepts the report when out_valid && out_ready
drop  output  1  one-cycle pulse: a report was discarded because the slot was full

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - out_code=0, out_err=0, out_valid=0, drop=0.
  - Synchronizer flops cleared to 0000000.
  - cand (candidate pattern) = 0000000, last (last reported pattern) = 0000000, cnt=0.
  - FSM in HOLD.
  - Reset asserted mid-operation aborts everything immediately, including a pending report.
- Synchronizer: 2-flop synchronizer on the 7-bit vector {a,b,c,d,e,f,g}, giving s2.
- Glyph table, pattern abcdefg -> out_code/out_err:
  - 1111110 -> 0/0
  - 0110000 -> 1/0
  - 1101101 -> 2/0
  - 1111001 -> 3/0
  - 1001111 -> 4/0 (overflow glyph; the encoder emits it for inputs 4-7)
  - Any other non-zero pattern -> 7/1
  - 0000000 is blank: never reported.
- FSM states and transitions:
  - HOLD: if s2 != cand, load cand<=s2, set cnt<=1, go to SETTLE. Otherwise stay.
  - SETTLE:
    - If s2 != cand: cand<=s2, cnt<=1, stay in SETTLE (restart).
    - Else if cnt==STABLE_CYCLES-1 (or STABLE_CYCLES==1): the pattern is accepted. If cand is blank or cand==last, go to HOLD and set last<=cand. Otherwise go to EMIT.
    - Else cnt<=cnt+1.
  - EMIT (1 cycle): last<=cand.
    - If slot free (!out_valid, or out_valid && out_ready this cycle): load out_code/out_err, out_valid<=1.
    - Else: leave the slot unchanged and pulse drop for one cycle.
    - Always go to HOLD.
- Blank handling: blank updates last, so the same digit shown again after a blank is reported again.
- Output slot:
  - out_valid clears on the out_valid && out_ready edge unless EMIT reloads it in that same cycle.
  - out_code/out_err remain stable while out_valid=1.
- Latency: input changes before edge k and then holds. out_valid rises after edge k+STABLE_CYCLES+2 (after edge k+6 at default).
- Glitch handling: a glitch shorter than STABLE_CYCLES synchronized cycles produces no report; the candidate restarts on every change.
- Counter width: cnt width is clog2(STABLE_CYCLES+1); cnt never wraps.

Optional Feature:
SEG_ACTIVE_LOW_EN:
- Defined: the segment inputs are inverted ahead of the synchronizer (common-anode display). An all-ones input is blank, and synchronizer/cand/last reset to the value matching all-ones input.
- Undefined: segments are active-high as tabulated above.
- The glyph table and all other behaviour are unchanged in both cases.

Test Plan:
- Reset, drive 1101101 steady, out_ready=1 -> single out_valid pulse with out_code=2, out_err=0, 6 cycles after the input edge; no further reports while the input holds.
- Step through 1111110, 0110000, 1111001, 1001111, holding each 20 cycles, out_ready=1 -> reports 0,1,3,4 in order, out_err=0.
- Drive 1111110 with a 2-cycle glitch to 0110000 mid-hold -> no report for 1; 0 is not re-reported.
- Sequence 0110000, 0000000, 0110000 (each 20 cycles) -> two reports of 1; the blank is never reported.
- Drive 1010101 -> out_code=7, out_err=1. Then, with out_ready=0, present 2 then 3 -> slot holds 7/1 and drop pulses once each for 2 and 3. Raising out_ready releases 7/1.
- Assert rst_n=0 while out_valid=1 and mid-SETTLE -> all outputs 0 immediately; after release, a held 1111001 is reported once as 3.
